// File: rtl/nibbler_pkg.sv
// nibbler_pkg: shared nibble-bus width and out_arb state encoding
package nibbler_pkg;
  localparam int NIBBLE_W = 4;
  typedef enum logic [1:0] {OA_IDLE, OA_WRITE, OA_HOLD} out_arb_state_t;
endpackage

// File: rtl/out_arb_rr_pick.sv
// out_arb_rr_pick: combinational round-robin picker, search starts at ptr and wraps
module out_arb_rr_pick #(
  parameter int NREQ = 4,
  parameter int ID_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic [NREQ-1:0] gnt,
  output logic [ID_W-1:0] idx,
  output logic            any
);
  logic [ID_W-1:0] j;
  // descending scan so the candidate closest to ptr is written last and wins
  always_comb begin
    idx = '0;
    j = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = ID_W'((int'(ptr) + k) % NREQ);
      if (req[j]) idx = j;
    end
  end
  assign any = |req;
  assign gnt = any ? NREQ'(1) << idx : '0;
endmodule

// File: rtl/out_arb.sv
// out_arb: round-robin LED nibble writer with post-write hold-off; OUT_ARB_PRIORITY_EN makes requester 0 strict-priority
module out_arb
  import nibbler_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int HOLD_CYCLES = 8,
  parameter int ID_W        = $clog2(NREQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NIBBLE_W*NREQ-1:0] req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic                     out_en,
  output logic [NIBBLE_W-1:0]      out_d,
  output logic [ID_W-1:0]          grant_id,
  output logic                     busy
);
  localparam int CNT_W = HOLD_CYCLES > 0 ? $clog2(HOLD_CYCLES + 1) : 1;
  out_arb_state_t state_q;
  logic [ID_W-1:0] ptr_q, ptr_d, next_ptr, pick_idx, win_idx;
  logic [CNT_W-1:0] cnt_q;
  logic [NREQ-1:0] pick_gnt, win_gnt;
  logic pick_any, accept;
  out_arb_rr_pick #(.NREQ(NREQ), .ID_W(ID_W)) u_pick (
    .req(req_valid),
    .ptr(ptr_q),
    .gnt(pick_gnt),
    .idx(pick_idx),
    .any(pick_any)
  );
  assign next_ptr = pick_idx == ID_W'(NREQ - 1) ? '0 : pick_idx + ID_W'(1);
`ifdef OUT_ARB_PRIORITY_EN
  // requester 0 bypasses the rotation and leaves the pointer where it was
  assign win_idx = req_valid[0] ? '0 : pick_idx;
  assign win_gnt = req_valid[0] ? NREQ'(1) : pick_gnt;
  assign ptr_d   = req_valid[0] ? ptr_q : next_ptr;
`else
  assign win_idx = pick_idx;
  assign win_gnt = pick_gnt;
  assign ptr_d   = next_ptr;
`endif
  assign accept    = !reset && state_q == OA_IDLE && pick_any;
  assign req_ready = accept ? win_gnt : '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= OA_IDLE;
      ptr_q    <= '0;
      cnt_q    <= '0;
      out_en   <= 1'b0;
      out_d    <= '0;
      grant_id <= '0;
      busy     <= 1'b0;
    end else begin
      case (state_q)
        OA_IDLE: if (accept) begin
          out_d    <= req_data[win_idx*NIBBLE_W +: NIBBLE_W];
          grant_id <= win_idx;
          ptr_q    <= ptr_d;
          out_en   <= 1'b1;
          busy     <= 1'b1;
          state_q  <= OA_WRITE;
        end
        OA_WRITE: begin
          out_en  <= 1'b0;
          cnt_q   <= CNT_W'(HOLD_CYCLES > 0 ? HOLD_CYCLES - 1 : 0);
          busy    <= HOLD_CYCLES > 0;
          state_q <= HOLD_CYCLES > 0 ? OA_HOLD : OA_IDLE;
        end
        OA_HOLD: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == '0) begin
            busy    <= 1'b0;
            state_q <= OA_IDLE;
          end
        end
        default: state_q <= OA_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_out_arb.sv
// tb_out_arb: table vectors, directed corner sequences and randomized traffic against a timeline model
module tb_out_arb;
  localparam int NREQ = 4;
  localparam int H = 8;
  typedef struct {
    logic [3:0]  v;
    logic [15:0] d;
    logic [3:0]  rdy;
    logic        en;
    logic [3:0]  od;
    logic [1:0]  gid;
    logic        busy;
  } vec_t;
  logic clk = 0, reset = 1;
  logic [3:0] req_valid = 0;
  logic [15:0] req_data = 0;
  logic [3:0] req_ready;
  logic out_en, busy;
  logic [3:0] out_d;
  logic [1:0] grant_id;
  logic rst2 = 1;
  logic [1:0] v2 = 0, r2;
  logic [7:0] d2 = 0;
  logic en2, g2, b2;
  logic [3:0] od2;
  int ncmp = 0, nfail = 0;
  int cyc = 0, last_acc = -100, next_free = 0, m_ptr = 0, m_gid = 0;
  logic [3:0] m_d = 0, acc_mask = 0;
  vec_t tv, tbl[11];
  bit tv_on = 0;

  always #5 clk = ~clk;

  out_arb #(.NREQ(4), .HOLD_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .out_en(out_en), .out_d(out_d), .grant_id(grant_id), .busy(busy)
  );
  out_arb #(.NREQ(2), .HOLD_CYCLES(0)) dut0 (
    .clk(clk), .reset(rst2), .req_valid(v2), .req_data(d2),
    .req_ready(r2), .out_en(en2), .out_d(od2), .grant_id(g2), .busy(b2)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  // model: one accept opens a write at +1, busy through +1+H, next accept no earlier than +2+H
  task automatic step();
    int w;
    bit pri;
    @(negedge clk);
    chk("out_en", 32'(out_en), 32'(cyc == last_acc + 1));
    chk("busy", 32'(busy), 32'(cyc >= last_acc + 1 && cyc <= last_acc + 1 + H));
    chk("out_d", 32'(out_d), 32'(m_d));
    chk("grant_id", 32'(grant_id), 32'(m_gid));
    acc_mask = 0;
    if (reset) begin
      chk("ready_in_reset", 32'(req_ready), 0);
      m_d = 0; m_gid = 0; m_ptr = 0; last_acc = -100; next_free = cyc + 1;
    end else if (cyc >= next_free && req_valid != 0) begin
      w = -1;
      pri = 0;
`ifdef OUT_ARB_PRIORITY_EN
      if (req_valid[0]) begin w = 0; pri = 1; end
`endif
      for (int k = 0; k < NREQ; k++)
        if (w < 0 && req_valid[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
      acc_mask = 4'(1 << w);
      chk("req_ready", 32'(req_ready), 32'(acc_mask));
      last_acc = cyc;
      next_free = cyc + 2 + H;
      m_d = req_data[4*w +: 4];
      m_gid = w;
      if (!pri) m_ptr = (w + 1) % NREQ;
    end else
      chk("req_ready_idle", 32'(req_ready), 0);
    if (tv_on) begin
      chk("tv_ready", 32'(req_ready), 32'(tv.rdy));
      chk("tv_en", 32'(out_en), 32'(tv.en));
      chk("tv_d", 32'(out_d), 32'(tv.od));
      chk("tv_gid", 32'(grant_id), 32'(tv.gid));
      chk("tv_busy", 32'(busy), 32'(tv.busy));
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1;
    req_valid = 0;
    step();
    step();
    reset = 0;
  endtask

  initial begin
    int a, r, found, bad, g0;
    int wc[$];
    logic [3:0] wd[$];
    logic [3:0] exp_seq[5];
    logic [3:0] pend;
    logic [15:0] pdat;
    bit prev;
    do_reset();
    // single request on 2 with nibble A
    for (int i = 0; i < 11; i++)
      tbl[i] = '{v: 4'b0000, d: 16'h0A00, rdy: 4'b0000, en: i == 1,
                 od: i == 0 ? 4'h0 : 4'hA, gid: i == 0 ? 2'd0 : 2'd2, busy: i >= 1 && i <= 9};
    tbl[0].v = 4'b0100;
    tbl[0].rdy = 4'b0100;
    tv_on = 1;
    for (int i = 0; i < 11; i++) begin
      tv = tbl[i];
      req_valid = tv.v;
      req_data = tv.d;
      step();
    end
    tv_on = 0;
`ifndef OUT_ARB_PRIORITY_EN
    // all four continuously valid: strict rotation 1,2,3,4,1 every 10 cycles
    do_reset();
    req_valid = 4'hF;
    req_data = 16'h4321;
    for (int i = 0; i < 45; i++) begin
      step();
      if (out_en) begin wc.push_back(cyc); wd.push_back(out_d); end
    end
    exp_seq = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h1};
    chk("rot_count", wc.size(), 5);
    for (int i = 0; i < wc.size() && i < 5; i++) begin
      chk("rot_data", 32'(wd[i]), 32'(exp_seq[i]));
      if (i > 0) chk("rot_spacing", wc[i] - wc[i-1], 10);
    end
`endif
    // request on 3 arriving during HOLD
    do_reset();
    req_valid = 4'b0001;
    req_data = 16'h7001;
    a = cyc;
    step();
    req_valid = 0;
    repeat (3) step();
    req_valid = 4'b1000;
    r = -1;
    for (int i = 0; i < 20 && r < 0; i++) begin
      step();
      if (req_ready[3]) r = cyc;
    end
    chk("hold_first_ready", r - a, 10);
    chk("hold_d_before", 32'(out_d), 1);
    step();
    req_valid = 0;
    chk("hold_d_after", 32'(out_d), 7);
    chk("hold_en_after", 32'(out_en), 1);
    // reset asserted during the WRITE cycle
    do_reset();
    req_valid = 4'b0100;
    req_data = 16'h0B00;
    step();
    req_valid = 0;
    reset = 1;
    step();
    reset = 0;
    chk("rw_en", 32'(out_en), 0);
    chk("rw_busy", 32'(busy), 0);
    chk("rw_d", 32'(out_d), 0);
    chk("rw_gid", 32'(grant_id), 0);
    req_valid = 4'b1010;
    req_data = 16'h6050;
    step();
    req_valid = 0;
    chk("rw_regrant_en", 32'(out_en), 1);
    chk("rw_regrant_gid", 32'(grant_id), 1);
    chk("rw_regrant_d", 32'(out_d), 5);
    // randomized traffic with occasional withdrawals and resets
    pend = 0;
    pdat = 0;
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < 4; i++) begin
        if (!pend[i] && $urandom_range(3) == 0) begin
          pend[i] = 1;
          pdat[4*i +: 4] = 4'($urandom);
        end else if (pend[i] && $urandom_range(60) == 0) pend[i] = 0;
      end
      reset = $urandom_range(80) == 0;
      req_valid = pend;
      req_data = pdat;
      step();
      pend &= ~acc_mask;
    end
    reset = 0;
    req_valid = 0;
`ifdef OUT_ARB_PRIORITY_EN
    do_reset();
    req_valid = 4'b0011;
    req_data = 16'h0021;
    bad = 0;
    g0 = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (req_ready[1]) bad++;
      if (req_ready[0]) g0++;
    end
    chk("prio_r1_blocked", bad, 0);
    chk("prio_r0_grants", g0, 4);
    req_valid = 4'b0010;
    found = -1;
    for (int i = 0; i < 15 && found < 0; i++) begin
      #1;
      if (req_ready[1]) found = cyc;
      else step();
    end
    chk("prio_r1_after_drop", 32'(found >= 0), 1);
    step();
    req_valid = 0;
`endif
    // HOLD_CYCLES=0 instance: accept every 2 cycles, alternating, never back-to-back strobes
    rst2 = 1;
    step();
    step();
    rst2 = 0;
    v2 = 2'b11;
    d2 = 8'h95;
    #1;
    prev = 0;
    for (int k = 0; k < 12; k++) begin
      chk("h0_ready", 32'(r2), k % 2 == 0 ? ((k / 2) % 2 == 0 ? 32'd1 : 32'd2) : 32'd0);
      chk("h0_en", 32'(en2), 32'(k % 2));
      chk("h0_busy", 32'(b2), 32'(k % 2));
      chk("h0_no_b2b", 32'(en2 & prev), 0);
      if (k % 2 == 1) begin
        chk("h0_d", 32'(od2), ((k - 1) / 2) % 2 == 0 ? 32'h5 : 32'h9);
        chk("h0_gid", 32'(g2), 32'(((k - 1) / 2) % 2));
      end
      prev = en2;
      step();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
